// File: rtl/instruction_controller.sv
// Multicycle control FSM for the 16-bit datapath: latches each fetched word and
// sequences FETCH/DECODE/EXECUTE (plus MEMWAIT/WRITEBACK for loads) into datapath strobes.
module instruction_controller #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        memData,
  output logic               memAddrSel,
  output logic [7:0]         instructionOp,
  output logic [WIDTH-1:0]   immediate,
  output logic [REGBITS-1:0] regAddA,
  output logic [REGBITS-1:0] regAddB,
  output logic [3:0]         ALUOp,
  output logic [1:0]         shiftOp,
  output logic [2:0]         busOp,
  output logic               immMUX,
  output logic               regWrite,
  output logic               memWrite,
  output logic               flagWrite,
  output logic               pcAdd,
  output logic               pcJump,
  output logic               pcBranch,
  output logic [3:0]         flagOp
);

  localparam logic [3:0] OP_RTYPE   = 4'b0000;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_SHIFT   = 4'b1000;
  localparam logic [3:0] OP_BCOND   = 4'b1100;
  localparam logic [3:0] OP_LUI     = 4'b1111;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [2:0] BUS_ALU   = 3'd0;
  localparam logic [2:0] BUS_SHIFT = 3'd1;
  localparam logic [2:0] BUS_MEM   = 3'd2;
  localparam logic [2:0] BUS_IMM   = 3'd3;
  localparam logic [2:0] BUS_PC    = 3'd4;

  localparam logic [3:0] COND_ALWAYS = 4'hE;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMWAIT, WRITEBACK} stateT;

  typedef struct packed {
    logic memAddrSel;
    logic regWrite;
    logic memWrite;
    logic flagWrite;
    logic pcJump;
    logic pcBranch;
  } strobesT;

  stateT       state;
  logic [15:0] ir;
  strobesT     strobe;

  wire [3:0] op  = ir[15:12];
  wire [3:0] ext = ir[7:4];

  function automatic logic isLoad(input logic [15:0] w);
    return (w[15:12] == OP_SPECIAL) && (w[7:4] == EXT_LOAD);
  endfunction

  // Strobes asserted in EXECUTE for a given instruction word.
  function automatic strobesT execStrobes(input logic [15:0] w);
    strobesT s;
    s = '0;
    case (w[15:12])
      OP_RTYPE: begin
        s.regWrite  = 1'b1;
        s.flagWrite = 1'b1;
      end
      OP_SHIFT: s.regWrite = 1'b1;
      OP_SPECIAL: begin
        case (w[7:4])
          EXT_LOAD:  s.memAddrSel = 1'b1;
          EXT_STOR: begin
            s.memAddrSel = 1'b1;
            s.memWrite   = 1'b1;
          end
          EXT_JAL: begin
            s.regWrite = 1'b1;
            s.pcJump   = 1'b1;
          end
          EXT_JCOND: s.pcJump = 1'b1;
          default:   s = '0;
        endcase
      end
      OP_BCOND: s.pcBranch = 1'b1;
      OP_LUI:   s.regWrite = 1'b1;
      default: begin
        s.regWrite  = 1'b1;
        s.flagWrite = 1'b1;
      end
    endcase
    return s;
  endfunction

  // Strobes are registered for the state being entered, so they come out glitch-free
  // and are already cleared in the first cycle after a reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      ir     <= '0;
      strobe <= '0;
      pcAdd  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this block
      // ordered against the old values; the field writes below override the defaults.
      strobe <= '0;
      pcAdd  <= 1'b0;
      unique case (state)
        FETCH: begin
          state <= DECODE;
          pcAdd <= 1'b1;
        end
        DECODE: begin
          ir     <= memData;
          state  <= EXECUTE;
          strobe <= execStrobes(memData);
        end
        EXECUTE: begin
          if (isLoad(ir)) begin
            state             <= MEMWAIT;
            strobe.memAddrSel <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        MEMWAIT: begin
          state           <= WRITEBACK;
          strobe.regWrite <= 1'b1;
        end
        WRITEBACK: state <= FETCH;
        default:   state <= FETCH;
      endcase
    end
  end

  assign memAddrSel = strobe.memAddrSel;
  assign regWrite   = strobe.regWrite;
  assign memWrite   = strobe.memWrite;
  assign flagWrite  = strobe.flagWrite;
  assign pcJump     = strobe.pcJump;
  assign pcBranch   = strobe.pcBranch;

  assign instructionOp = {op, ext};
  assign regAddA       = ir[REGBITS-1:0];
  assign regAddB       = ir[8 +: REGBITS];

  // Field decode follows IR directly so it is stable for the whole instruction.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    ALUOp     = '0;
    shiftOp   = '0;
    busOp     = BUS_ALU;
    immMUX    = 1'b0;
    flagOp    = '0;
    immediate = {{(WIDTH-8){ir[7]}}, ir[7:0]};
    case (op)
      OP_RTYPE: ALUOp = ext;
      OP_SHIFT: begin
        shiftOp   = ext[1:0];
        immMUX    = ext[2];
        immediate = {{(WIDTH-4){1'b0}}, ir[3:0]};
        busOp     = BUS_SHIFT;
      end
      OP_SPECIAL: begin
        case (ext)
          EXT_LOAD:  busOp = BUS_MEM;
          EXT_JAL: begin
            busOp  = BUS_PC;
            flagOp = COND_ALWAYS;
          end
          EXT_JCOND: flagOp = ir[11:8];
          default:   busOp = BUS_ALU;
        endcase
      end
      OP_BCOND: flagOp = ir[11:8];
      OP_LUI: begin
        immediate = {ir[7:0], {(WIDTH-8){1'b0}}};
        busOp     = BUS_IMM;
      end
      default: begin
        ALUOp  = op;
        immMUX = 1'b1;
      end
    endcase
  end

endmodule
